// File: rtl/emit_sequence.sv
// rtl/emit_sequence.sv - parallel-in, MSB-first serial transmitter with one-entry pending buffer
module emit_sequence #(
  parameter int   W          = 8,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_w,
  output logic         in_accept,
  output logic         out_r,
  output logic         out_vld_r,
  output logic         tx_done_r,
  output logic         busy_r
);

  localparam int BW = $clog2(W);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t          state_r;
  logic [W-1:0]    pend_r;
  logic            pend_vld_r;
  logic [W-1:0]    shift_r;
  logic [BW-1:0]   bit_cnt_r;
  logic [GW-1:0]   gap_cnt_r;

  // The buffer flag alone decides acceptance, so in_vld never reaches in_accept.
  assign in_accept = ~pend_vld_r;

  // Busy covers both a word on the wire (or in its trailing gap) and a word waiting.
  assign busy_r = (state_r != S_IDLE) | pend_vld_r;

  // Handshake capture, shifter sequencing and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      pend_r     <= '0;
      pend_vld_r <= 1'b0;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      gap_cnt_r  <= '0;
      out_r      <= IDLE_LEVEL;
      out_vld_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;

      // A transfer and a load never coincide: the load needs a full buffer,
      // which holds in_accept low.
      if (in_vld && in_accept) begin
        pend_r     <= in_w;
        pend_vld_r <= 1'b1;
      end

      case (state_r)
        S_IDLE: begin
          out_r     <= IDLE_LEVEL;
          out_vld_r <= 1'b0;
          if (pend_vld_r) begin
            shift_r    <= pend_r;
            out_r      <= pend_r[W-1];
            out_vld_r  <= 1'b1;
            bit_cnt_r  <= BW'(W - 1);
            pend_vld_r <= 1'b0;
            state_r    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (bit_cnt_r != '0) begin
            // shift_r[W-1] is already on out_r, so the next bit is one below it.
            shift_r   <= shift_r << 1;
            out_r     <= shift_r[W-2];
            bit_cnt_r <= bit_cnt_r - 1'b1;
            tx_done_r <= (bit_cnt_r == BW'(1));
          end else if (GAP > 0) begin
            gap_cnt_r <= GW'(GAP - 1);
            out_r     <= IDLE_LEVEL;
            out_vld_r <= 1'b0;
            state_r   <= S_GAP;
          end else if (pend_vld_r) begin
            // Reload straight from the buffer so consecutive words abut.
            shift_r    <= pend_r;
            out_r      <= pend_r[W-1];
            out_vld_r  <= 1'b1;
            bit_cnt_r  <= BW'(W - 1);
            pend_vld_r <= 1'b0;
          end else begin
            out_r     <= IDLE_LEVEL;
            out_vld_r <= 1'b0;
            state_r   <= S_IDLE;
          end
        end

        S_GAP: begin
          out_r     <= IDLE_LEVEL;
          out_vld_r <= 1'b0;
          if (gap_cnt_r != '0) begin
            gap_cnt_r <= gap_cnt_r - 1'b1;
          end else if (pend_vld_r) begin
            shift_r    <= pend_r;
            out_r      <= pend_r[W-1];
            out_vld_r  <= 1'b1;
            bit_cnt_r  <= BW'(W - 1);
            pend_vld_r <= 1'b0;
            state_r    <= S_SHIFT;
          end else begin
            state_r <= S_IDLE;
          end
        end

        default: begin
          out_r     <= IDLE_LEVEL;
          out_vld_r <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emit_sequence.sv
// tb/tb_emit_sequence.sv - randomized self-checking bench for emit_sequence (GAP=0 and GAP=2 instances)
module tb_emit_sequence;

  localparam int W  = 8;
  localparam int G1 = 2;
  localparam logic [1:0] IDLE_LV = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_vld [2];
  logic [W-1:0] in_w   [2];
  logic [1:0]   in_accept, out_r, out_vld_r, tx_done_r, busy_r;

  emit_sequence #(.W(W), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld[0]), .in_w(in_w[0]),
    .in_accept(in_accept[0]), .out_r(out_r[0]), .out_vld_r(out_vld_r[0]),
    .tx_done_r(tx_done_r[0]), .busy_r(busy_r[0])
  );

  emit_sequence #(.W(W), .GAP(G1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld[1]), .in_w(in_w[1]),
    .in_accept(in_accept[1]), .out_r(out_r[1]), .out_vld_r(out_vld_r[1]),
    .tx_done_r(tx_done_r[1]), .busy_r(busy_r[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: every accepted word gets a schedule (accept edge, first-bit edge).
  int           ev_e [2][256];
  int           ev_s [2][256];
  logic [W-1:0] ev_w [2][256];
  int           nq     [2] = '{0, 0};
  int           last_l [2] = '{-100, -100};

  // Per-cycle logs, packed as {out_vld, out_bit, tx_done, in_accept, busy}.
  logic [4:0] obs  [2][4096];
  logic [4:0] expv [2][4096];

  logic [W-1:0] sent [2][64];
  int           nsent [2] = '{0, 0};

  function automatic int gap_of(input int d);
    return (d == 1) ? G1 : 0;
  endfunction

  // A word starts one edge after acceptance, but never before the previous word
  // and its gap are finished.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        nq[d]     = 0;
        last_l[d] = -100;
      end else if (in_vld[d] && in_accept[d]) begin
        int s;
        s = cyc + 1;
        if (last_l[d] + 1 + gap_of(d) > s) s = last_l[d] + 1 + gap_of(d);
        ev_e[d][nq[d]] = cyc;
        ev_s[d][nq[d]] = s;
        ev_w[d][nq[d]] = in_w[d];
        last_l[d]      = s + W - 1;
        nq[d]          = nq[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic v, b, dn, pend, bsy;
      v = 1'b0; b = IDLE_LV[d]; dn = 1'b0; pend = 1'b0; bsy = 1'b0;
      for (int k = 0; k < nq[d]; k++) begin
        if (cyc >= ev_s[d][k] && cyc <= ev_s[d][k] + W - 1) begin
          v  = 1'b1;
          b  = ev_w[d][k][W-1-(cyc-ev_s[d][k])];
          dn = (cyc == ev_s[d][k] + W - 1);
        end
        if (cyc >= ev_e[d][k] && cyc < ev_s[d][k]) pend = 1'b1;
        if (cyc >= ev_s[d][k] && cyc <= ev_s[d][k] + W - 1 + gap_of(d)) bsy = 1'b1;
      end
      expv[d][cyc] = {v, b, dn, ~pend, bsy | pend};
      obs[d][cyc]  = {out_vld_r[d], out_r[d], tx_done_r[d], in_accept[d], busy_r[d]};
    end
  end

  task automatic push(input int d, input logic [W-1:0] w);
    logic ok;
    ok = 1'b0;
    in_vld[d] = 1'b1;
    in_w[d]   = w;
    for (int n = 0; n < 200; n++) begin
      if (in_accept[d]) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout dut%0d word %h in_accept=0 required 1 within 200 cycles", d, w);
    end
  endtask

  task automatic release_in(input int d);
    in_vld[d] = 1'b0;
    in_w[d]   = W'($urandom);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    in_vld[0] = 1'b1; in_vld[1] = 1'b1;
    in_w[0] = 8'hA5; in_w[1] = 8'h5A;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({out_vld_r[d], out_r[d], tx_done_r[d], in_accept[d], busy_r[d]} !== {1'b0, IDLE_LV[d], 1'b0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL reset_state dut%0d got %b required %b", d,
                   {out_vld_r[d], out_r[d], tx_done_r[d], in_accept[d], busy_r[d]}, {1'b0, IDLE_LV[d], 1'b0, 1'b1, 1'b0});
        end
      end
    end
    rst = 1'b0;
    release_in(0); release_in(1);
    wait_cycles(4);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_vld_r[d], busy_r[d]} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_capture dut%0d vld/busy got %b required 00", d, {out_vld_r[d], busy_r[d]});
      end
    end
  endtask

  task automatic test_single();
    int c0;
    logic [W-1:0] w;
    logic q[$];
    w  = 8'h9A;
    c0 = cyc;
    push(0, w);
    release_in(0);
    wait_cycles(14);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (obs[0][c0+2+i][4:2] !== {1'b1, w[W-1-i], (i == W-1)}) begin
        errors++;
        $display("FAIL single_bit%0d got vld/bit/done %b required %b", W-1-i, obs[0][c0+2+i][4:2], {1'b1, w[W-1-i], (i == W-1)});
      end
    end
    checks++;
    if (obs[0][c0+2+W][4] !== 1'b0 || obs[0][c0+3+W][0] !== 1'b0) begin
      errors++;
      $display("FAIL single_return_idle vld %b busy %b required 0 0", obs[0][c0+2+W][4], obs[0][c0+3+W][0]);
    end
    for (int c = c0; c < cyc; c++) if (obs[0][c][4]) q.push_back(obs[0][c][3]);
    checks++;
    if (q.size() != W) begin
      errors++;
      $display("FAIL single_vld_count got %0d required %0d", q.size(), W);
    end
    for (int d = 0; d < 2; d++)
      for (int c = c0; c < cyc; c++) begin
        checks++;
        if (obs[d][c] !== expv[d][c]) begin
          errors++;
          $display("FAIL single_model dut%0d cyc %0d got %b required %b", d, c, obs[d][c], expv[d][c]);
        end
      end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [15:0] ref_s;
    logic [15:0] got;
    int n;
    ref_s = 16'h9A55;
    c0 = cyc;
    push(0, 8'h9A);
    push(0, 8'h55);
    release_in(0);
    wait_cycles(22);
    checks++;
    if (obs[0][c0+5][1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept_low got %b required 0", obs[0][c0+5][1]);
    end
    n = 0; got = '0;
    for (int c = c0 + 2; c < c0 + 18; c++) begin
      if (obs[0][c][4]) n++;
      got = {got[14:0], obs[0][c][3]};
    end
    checks++;
    if (n != 16 || got !== ref_s) begin
      errors++;
      $display("FAIL b2b_stream got %0d valid bits %h required 16 valid bits %h", n, got, ref_s);
    end
    for (int d = 0; d < 2; d++)
      for (int c = c0; c < cyc; c++) begin
        checks++;
        if (obs[d][c] !== expv[d][c]) begin
          errors++;
          $display("FAIL b2b_model dut%0d cyc %0d got %b required %b", d, c, obs[d][c], expv[d][c]);
        end
      end
  endtask

  task automatic test_gap();
    int c0;
    logic [1:0] want;
    c0 = cyc;
    push(1, 8'hFF);
    push(1, 8'h00);
    release_in(1);
    wait_cycles(26);
    for (int i = 0; i < 18; i++) begin
      if (i < 8)       want = 2'b11;
      else if (i < 10) want = 2'b01;
      else             want = 2'b10;
      checks++;
      if (obs[1][c0+2+i][4:3] !== want) begin
        errors++;
        $display("FAIL gap_pattern offset %0d vld/bit got %b required %b", i, obs[1][c0+2+i][4:3], want);
      end
    end
    for (int d = 0; d < 2; d++)
      for (int c = c0; c < cyc; c++) begin
        checks++;
        if (obs[d][c] !== expv[d][c]) begin
          errors++;
          $display("FAIL gap_model dut%0d cyc %0d got %b required %b", d, c, obs[d][c], expv[d][c]);
        end
      end
  endtask

  task automatic test_backpressure();
    for (int d = 0; d < 2; d++) begin
      int c0;
      logic [W-1:0] words [4];
      logic q[$];
      int bad;
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
        words[i] = W'($urandom);
        push(d, words[i]);
      end
      release_in(d);
      wait_cycles(4 * (W + G1) + 6);
      for (int c = c0; c < cyc; c++) if (obs[d][c][4]) q.push_back(obs[d][c][3]);
      checks++;
      if (q.size() != 4 * W) begin
        errors++;
        $display("FAIL bp_bit_count dut%0d got %0d required %0d", d, q.size(), 4 * W);
      end else begin
        bad = 0;
        for (int i = 0; i < 4; i++)
          for (int b = 0; b < W; b++)
            if (q[i*W+b] !== words[i][W-1-b]) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL bp_scoreboard dut%0d got %0d wrong bits required 0", d, bad);
        end
      end
      for (int c = c0; c < cyc; c++) begin
        checks++;
        if (obs[d][c] !== expv[d][c]) begin
          errors++;
          $display("FAIL bp_model dut%0d cyc %0d got %b required %b", d, c, obs[d][c], expv[d][c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int c0, nv, nd;
    c0 = cyc;
    push(0, 8'h9A);
    push(0, 8'h3C);
    release_in(0);
    wait_cycles(1);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(20);
    nv = 0; nd = 0;
    for (int c = c0; c < cyc; c++) begin
      if (obs[0][c][4]) nv++;
      if (obs[0][c][2]) nd++;
    end
    checks++;
    if (nv != 3 || nd != 0) begin
      errors++;
      $display("FAIL rst_mid_partial got %0d valid bits %0d done required 3 valid bits 0 done", nv, nd);
    end
    for (int c = c0 + 5; c < cyc; c++) begin
      checks++;
      if (obs[0][c][4] !== 1'b0 || obs[0][c][0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after cyc %0d vld %b busy %b required 0 0", c, obs[0][c][4], obs[0][c][0]);
      end
    end
  endtask

  task automatic drive_rand(input int d);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      if (g > 0) begin
        release_in(d);
        wait_cycles(g);
      end
      sent[d][nsent[d]] = W'($urandom);
      push(d, sent[d][nsent[d]]);
      nsent[d]++;
    end
    release_in(d);
  endtask

  task automatic test_random();
    int c0;
    c0 = cyc;
    nsent[0] = 0; nsent[1] = 0;
    fork
      drive_rand(0);
      drive_rand(1);
    join
    wait_cycles(2 * (W + G1) + 6);
    for (int d = 0; d < 2; d++) begin
      logic q[$];
      int bad;
      for (int c = c0; c < cyc; c++) if (obs[d][c][4]) q.push_back(obs[d][c][3]);
      checks++;
      if (q.size() != nsent[d] * W) begin
        errors++;
        $display("FAIL rand_bit_count dut%0d got %0d required %0d", d, q.size(), nsent[d] * W);
      end else begin
        bad = 0;
        for (int i = 0; i < nsent[d]; i++)
          for (int b = 0; b < W; b++)
            if (q[i*W+b] !== sent[d][i][W-1-b]) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rand_scoreboard dut%0d got %0d wrong bits required 0", d, bad);
        end
      end
      for (int c = c0; c < cyc; c++) begin
        checks++;
        if (obs[d][c] !== expv[d][c]) begin
          errors++;
          $display("FAIL rand_model dut%0d cyc %0d got %b required %b", d, c, obs[d][c], expv[d][c]);
        end
      end
    end
  endtask

  initial begin
    in_vld[0] = 1'b0; in_vld[1] = 1'b0;
    in_w[0] = '0; in_w[1] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
